// File: rtl/cache_pkg.sv
// Shared types and field widths for the direct-mapped L1 data-cache controller.
package cache_pkg;

   localparam int ADDR_W   = 64;
   localparam int DATA_W   = 64;
   localparam int WPL      = 8;                 // words per line
   localparam int NSETS    = 64;
   localparam int STRB_W   = DATA_W / 8;
   localparam int OFFSET_W = 6;
   localparam int INDEX_W  = 6;
   localparam int WSEL_W   = 3;
   localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WB_REQ,
      FILL_REQ,
      FILL_WAIT,
      RESPOND
   } state_e;

   typedef logic [WPL-1:0][DATA_W-1:0] line_t;

   // Byte-granular merge of store data into an existing word.
   function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [STRB_W-1:0] wstrb);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int b = 0; b < STRB_W; b++) begin
         if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_line_store.sv
// Flop-based line storage: valid/dirty/tag/data per set, combinational read,
// synchronous fill, strobed word write and dirty-clear ports.
module dm_line_store
   import cache_pkg::*;
#(
   parameter int SETS = NSETS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INDEX_W-1:0] idx_i,
   output logic               valid_o,
   output logic               dirty_o,
   output logic [TAG_W-1:0]   tag_o,
   output line_t              line_o,
   input  logic               fill_en_i,
   input  logic [TAG_W-1:0]   fill_tag_i,
   input  line_t              fill_line_i,
   input  logic               wr_en_i,
   input  logic [WSEL_W-1:0]  wr_word_i,
   input  logic [DATA_W-1:0]  wr_data_i,
   input  logic [STRB_W-1:0]  wr_strb_i,
   input  logic               dclr_en_i
);

   logic [SETS-1:0]  valid_q;
   logic [SETS-1:0]  dirty_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   line_t            data_q [SETS];

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign line_o  = data_q[idx_i];

   // Status bits: cleared on reset; a fill makes the line valid and clean,
   // a store marks it dirty, an accepted writeback cleans it.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
         end
         if (wr_en_i)   dirty_q[idx_i] <= 1'b1;
         if (dclr_en_i) dirty_q[idx_i] <= 1'b0;
      end
   end

   // Tag and data arrays carry no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (fill_en_i) begin
         tag_q[idx_i]  <= fill_tag_i;
         data_q[idx_i] <= fill_line_i;
      end else if (wr_en_i) begin
         data_q[idx_i][wr_word_i] <= merge_word(data_q[idx_i][wr_word_i], wr_data_i, wr_strb_i);
      end
   end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back / write-allocate L1 D-cache controller. One CPU
// request at a time; misses go out as whole-line writeback and fill commands.
module dm_cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_W,
   parameter int DATA_WIDTH     = DATA_W,
   parameter int WORDS_PER_LINE = WPL,
   parameter int SETS           = NSETS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 req_valid_i,
   output logic                                 req_ready_o,
   input  logic                                 req_we_i,
   input  logic [ADDR_WIDTH-1:0]                req_addr_i,
   input  logic [DATA_WIDTH-1:0]                req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]              req_wstrb_i,
   output logic                                 resp_valid_o,
   output logic [DATA_WIDTH-1:0]                resp_rdata_o,
   output logic                                 mem_cmd_valid_o,
   output logic                                 mem_cmd_store_o,
   output logic [ADDR_WIDTH-1:0]                mem_cmd_addr_o,
   output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_cmd_data_o,
   input  logic                                 mem_bus_ready_i,
   input  logic                                 mem_bus_valid_i,
   input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_bus_data_i,
   output logic                                 mem_fill_ready_o
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:3]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [INDEX_W-1:0]  idx;
   logic [TAG_W-1:0]    tag;
   logic [WSEL_W-1:0]   wsel;
   logic                st_valid, st_dirty;
   logic [TAG_W-1:0]    st_tag;
   line_t               st_line;
   logic                hit;
   logic [DATA_W-1:0]   sel_word, merged;
   logic                wr_en, fill_en, dclr_en;

   // Byte offset within a word is irrelevant to 64-bit accesses.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr_i[2:0];

   assign idx      = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign tag      = addr_q[ADDR_W-1:OFFSET_W+INDEX_W];
   assign wsel     = addr_q[OFFSET_W-1:3];
   assign hit      = st_valid && (st_tag == tag);
   assign sel_word = st_line[wsel];
   assign merged   = merge_word(sel_word, wdata_q, wstrb_q);

   dm_line_store #(.SETS(SETS)) u_store (
      .clk         (clk),
      .reset       (reset),
      .idx_i       (idx),
      .valid_o     (st_valid),
      .dirty_o     (st_dirty),
      .tag_o       (st_tag),
      .line_o      (st_line),
      .fill_en_i   (fill_en),
      .fill_tag_i  (tag),
      .fill_line_i (line_t'(mem_bus_data_i)),
      .wr_en_i     (wr_en),
      .wr_word_i   (wsel),
      .wr_data_i   (wdata_q),
      .wr_strb_i   (wstrb_q),
      .dclr_en_i   (dclr_en)
   );

   // State register, response data and request capture in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         if (state_q == IDLE && req_valid_i) begin
            addr_q  <= req_addr_i[ADDR_W-1:3];
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
         end
      end
   end

   // Next-state and outputs; command fields depend only on state and the
   // stored line, so they stay stable while the adapter is not ready.
   always_comb begin
      state_d          = state_q;
      rdata_d          = rdata_q;
      req_ready_o      = 1'b0;
      resp_valid_o     = 1'b0;
      resp_rdata_o     = '0;
      mem_cmd_valid_o  = 1'b0;
      mem_cmd_store_o  = 1'b0;
      mem_cmd_addr_o   = '0;
      mem_cmd_data_o   = '0;
      mem_fill_ready_o = 1'b0;
      wr_en            = 1'b0;
      fill_en          = 1'b0;
      dclr_en          = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               if (we_q) begin
                  wr_en   = 1'b1;
                  rdata_d = merged;
               end else begin
                  rdata_d = sel_word;
               end
               state_d = RESPOND;
            end else if (st_valid && st_dirty) begin
               state_d = WB_REQ;
            end else begin
               state_d = FILL_REQ;
            end
         end
         WB_REQ: begin
            mem_cmd_valid_o = 1'b1;
            mem_cmd_store_o = 1'b1;
            mem_cmd_addr_o  = {st_tag, idx, {OFFSET_W{1'b0}}};
            mem_cmd_data_o  = st_line;
            if (mem_bus_ready_i) begin
               dclr_en = 1'b1;
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: begin
            mem_cmd_valid_o = 1'b1;
            mem_cmd_addr_o  = {tag, idx, {OFFSET_W{1'b0}}};
            if (mem_bus_ready_i) state_d = FILL_WAIT;
         end
         FILL_WAIT: begin
            mem_fill_ready_o = 1'b1;
            if (mem_bus_valid_i) begin
               fill_en = 1'b1;
               state_d = LOOKUP;
            end
         end
         RESPOND: begin
            resp_valid_o = 1'b1;
            resp_rdata_o = rdata_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed plus randomized bench; the bench plays the memory adapter and keeps
// a set-level reference model of the cache and backing memory.
module tb_dm_cache_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid, req_ready, req_we;
   logic [63:0]  req_addr, req_wdata;
   logic [7:0]   req_wstrb;
   logic         resp_valid;
   logic [63:0]  resp_rdata;
   logic         mem_cmd_valid, mem_cmd_store;
   logic [63:0]  mem_cmd_addr;
   logic [511:0] mem_cmd_data;
   logic         mem_bus_ready, mem_bus_valid;
   logic [511:0] mem_bus_data;
   logic         mem_fill_ready;

   int tests = 0;
   int fails = 0;

   // reference model
   bit           mv [64];
   bit           md [64];
   logic [51:0]  mt [64];
   logic [511:0] mdat [64];
   logic [511:0] mem [logic [63:0]];
   logic [63:0]  last_rd;

   always #5 clk = ~clk;

   dm_cache_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_we_i         (req_we),
      .req_addr_i       (req_addr),
      .req_wdata_i      (req_wdata),
      .req_wstrb_i      (req_wstrb),
      .resp_valid_o     (resp_valid),
      .resp_rdata_o     (resp_rdata),
      .mem_cmd_valid_o  (mem_cmd_valid),
      .mem_cmd_store_o  (mem_cmd_store),
      .mem_cmd_addr_o   (mem_cmd_addr),
      .mem_cmd_data_o   (mem_cmd_data),
      .mem_bus_ready_i  (mem_bus_ready),
      .mem_bus_valid_i  (mem_bus_valid),
      .mem_bus_data_i   (mem_bus_data),
      .mem_fill_ready_o (mem_fill_ready)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Backing memory: untouched lines carry an address-derived pattern.
   function automatic logic [511:0] get_line(input logic [63:0] la);
      logic [511:0] l;
      if (mem.exists(la)) return mem[la];
      for (int w = 0; w < 8; w++) l[w*64 +: 64] = {la[31:0], 32'(w) * 32'h0101_0101};
      return l;
   endfunction

   // One CPU request, issued from IDLE at a negedge; dly stretches each
   // adapter handshake; rst_fill pulses reset while the fill is outstanding.
   task automatic do_req(input bit we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] ws, input int dly, input bit rst_fill);
      int           set;
      logic [51:0]  tg;
      int           wsl;
      logic [63:0]  la, va, w;
      logic [511:0] fl;
      bit           hit;
      set = int'(a[11:6]);
      tg  = a[63:12];
      wsl = int'(a[5:3]);
      la  = {a[63:6], 6'b0};
      chk("idle_ready", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
      tick();
      req_valid = 1'b0;
      chk("lookup_busy", req_ready, 0);
      chk("lookup_nocmd", mem_cmd_valid, 0);
      chk("lookup_noresp", resp_valid, 0);
      hit = mv[set] && (mt[set] == tg);
      if (!hit) begin
         if (mv[set] && md[set]) begin
            va = {mt[set], 6'(set), 6'b0};
            tick();
            chk("wb_valid", mem_cmd_valid, 1);
            chk("wb_store", mem_cmd_store, 1);
            chk("wb_addr", mem_cmd_addr, va);
            chk("wb_data", mem_cmd_data, mdat[set]);
            for (int i = 0; i < dly; i++) begin
               tick();
               chk("wb_hold_valid", mem_cmd_valid, 1);
               chk("wb_hold_store", mem_cmd_store, 1);
               chk("wb_hold_addr", mem_cmd_addr, va);
               chk("wb_hold_data", mem_cmd_data, mdat[set]);
            end
            mem_bus_ready = 1'b1;
            tick();
            mem_bus_ready = 1'b0;
            mem[va] = mdat[set];
            md[set] = 1'b0;
         end else begin
            tick();
         end
         chk("fill_valid", mem_cmd_valid, 1);
         chk("fill_store", mem_cmd_store, 0);
         chk("fill_addr", mem_cmd_addr, la);
         chk("fill_rdy_low", mem_fill_ready, 0);
         for (int i = 0; i < dly; i++) begin
            // stray bus_valid and CPU requests here must have no effect
            mem_bus_valid = 1'b1;
            mem_bus_data  = {16{$urandom}};
            req_valid     = 1'b1;
            tick();
            chk("fill_hold_valid", mem_cmd_valid, 1);
            chk("fill_hold_store", mem_cmd_store, 0);
            chk("fill_hold_addr", mem_cmd_addr, la);
            chk("fill_hold_busy", req_ready, 0);
         end
         mem_bus_valid = 1'b0;
         req_valid     = 1'b0;
         mem_bus_ready = 1'b1;
         tick();
         mem_bus_ready = 1'b0;
         chk("fwait_nocmd", mem_cmd_valid, 0);
         chk("fwait_ready", mem_fill_ready, 1);
         if (rst_fill) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("rst_ready", req_ready, 1);
            chk("rst_nocmd", mem_cmd_valid, 0);
            chk("rst_nofill", mem_fill_ready, 0);
            chk("rst_noresp", resp_valid, 0);
            for (int s = 0; s < 64; s++) begin mv[s] = 1'b0; md[s] = 1'b0; end
            return;
         end
         for (int i = 0; i < dly; i++) begin
            tick();
            chk("fwait_hold", mem_fill_ready, 1);
         end
         fl = get_line(la);
         mem_bus_valid = 1'b1;
         mem_bus_data  = fl;
         tick();
         mem_bus_valid = 1'b0;
         mv[set] = 1'b1; md[set] = 1'b0; mt[set] = tg; mdat[set] = fl;
         chk("replay_nocmd", mem_cmd_valid, 0);
         chk("replay_noresp", resp_valid, 0);
      end
      w = mdat[set][wsl*64 +: 64];
      if (we) begin
         for (int b = 0; b < 8; b++) if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
         mdat[set][wsl*64 +: 64] = w;
         md[set] = 1'b1;
      end
      tick();
      chk("resp_valid", resp_valid, 1);
      chk("resp_rdata", resp_rdata, w);
      last_rd = resp_rdata;
      tick();
      chk("resp_pulse", resp_valid, 0);
      chk("back_idle", req_ready, 1);
   endtask

   initial begin
      logic [511:0] l0;
      logic [63:0]  a;
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      mem_bus_ready = 1'b0; mem_bus_valid = 1'b0; mem_bus_data = '0;
      for (int w = 0; w < 8; w++) l0[w*64 +: 64] = 64'(w + 1) * 64'h11;
      mem[64'h1000] = l0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_cmd_valid", mem_cmd_valid, 0);
      chk("rst_cmd_store", mem_cmd_store, 0);
      chk("rst_cmd_addr", mem_cmd_addr, 0);
      chk("rst_cmd_data", mem_cmd_data, 0);
      chk("rst_fill_ready", mem_fill_ready, 0);

      do_req(1'b0, 64'h1000, 64'h0, 8'h00, 0, 1'b0);            // cold miss
      chk("plan1_word0", last_rd, 64'h11);
      do_req(1'b0, 64'h1008, 64'h0, 8'h00, 0, 1'b0);            // hit
      chk("plan2_word1", last_rd, 64'h22);
      do_req(1'b1, 64'h1010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 1'b0);
      chk("plan3_merge", last_rd, 64'h0000_0000_FFFF_FFFF);
      do_req(1'b0, 64'h2010, 64'h0, 8'h00, 5, 1'b0);            // dirty eviction
      do_req(1'b1, 64'h3000, 64'hDEAD_BEEF_0123_4567, 8'hF0, 1, 1'b0); // store miss, clean victim
      do_req(1'b0, 64'h4000, 64'h0, 8'h00, 2, 1'b0);            // evicts dirty 0x3000
      do_req(1'b0, 64'h5040, 64'h0, 8'h00, 1, 1'b1);            // reset mid-fill
      do_req(1'b0, 64'h2010, 64'h0, 8'h00, 0, 1'b0);            // misses after reset

      for (int n = 0; n < 40; n++) begin
         a = (64'($urandom_range(1, 4)) << 12) | (64'($urandom_range(0, 2)) << 6) |
             (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
         do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
                $urandom_range(0, 3), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
